// File: rtl/root_rank_inject.sv
// Credit-paced injection FIFO between the root rank stage and the quadtree router root port.
// Optional same-edge bypass into an empty FIFO: define ROOT_INJECT_BYPASS_EN.
module root_rank_inject #(
    parameter int DEPTH        = 4,
    parameter int CREDIT       = 4,
    parameter int ROUTER_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    router_rdy,
    input  logic                    rank_tx_en,
    input  logic [ROUTER_WIDTH-1:0] rank_tx_data,
    output logic                    out_data_valid,
    output logic [ROUTER_WIDTH-1:0] out_data,
    input  logic                    credit_in,
    output logic [3:0]              credit_cnt,
    output logic                    inject_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_L  = CW'(DEPTH);
    localparam logic [3:0]    CREDIT_L = 4'(CREDIT);

    logic [ROUTER_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic wr_acc;
    logic bypass;
    logic push;
    logic send_fifo;
    logic send;
    logic credit_ovf;

    // Handshake: a packet transfers on any edge where rank_tx_en && router_rdy;
    // router_rdy is a function of registered occupancy only.
    assign router_rdy = (count != DEPTH_L);

    always_comb begin
        wr_acc    = rank_tx_en && router_rdy;
        send_fifo = (count != '0) && (credit_cnt != '0);
`ifdef ROOT_INJECT_BYPASS_EN
        bypass    = wr_acc && (count == '0) && (credit_cnt != '0);
`else
        bypass    = 1'b0;
`endif
        push       = wr_acc && !bypass;
        send       = send_fifo || bypass;
        credit_ovf = credit_in && (credit_cnt == CREDIT_L) && !send;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rank_tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            credit_cnt     <= CREDIT_L;
            out_data_valid <= 1'b0;
            out_data       <= '0;
            inject_err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (send_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(send_fifo);

            // A returned credit and a send in the same cycle cancel out.
            if (credit_in && !credit_ovf && !send) begin
                credit_cnt <= credit_cnt + 4'd1;
            end else if (send && !credit_in) begin
                credit_cnt <= credit_cnt - 4'd1;
            end

            out_data_valid <= send;
            if (send_fifo) begin
                out_data <= mem[rd_ptr];
            end else if (bypass) begin
                out_data <= rank_tx_data;
            end

            if ((rank_tx_en && !router_rdy) || credit_ovf) begin
                inject_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_root_rank_inject.sv
// Scoreboard bench for root_rank_inject: directed test-plan scenarios followed by random traffic.
module tb_root_rank_inject;
    localparam int DEPTH  = 4;
    localparam int CREDIT = 4;
    localparam int W      = 8;
`ifdef ROOT_INJECT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         router_rdy;
    logic         rank_tx_en;
    logic [W-1:0] rank_tx_data;
    logic         out_data_valid;
    logic [W-1:0] out_data;
    logic         credit_in;
    logic [3:0]   credit_cnt;
    logic         inject_err;

    root_rank_inject #(.DEPTH(DEPTH), .CREDIT(CREDIT), .ROUTER_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .router_rdy     (router_rdy),
        .rank_tx_en     (rank_tx_en),
        .rank_tx_data   (rank_tx_data),
        .out_data_valid (out_data_valid),
        .out_data       (out_data),
        .credit_in      (credit_in),
        .credit_cnt     (credit_cnt),
        .inject_err     (inject_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int           m_count;
    int           m_credit;
    logic         m_err;
    logic [W-1:0] last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count   = 0;
        m_credit  = CREDIT;
        m_err     = 1'b0;
        last_data = '0;
    endtask

    // One clock: drive inputs, advance the reference model, sample #1 after the edge.
    task automatic step(input logic en, input logic [W-1:0] d, input logic cr);
        logic rdy, acc, byp, sf, snd, ovf;
        logic [W-1:0] e;
        rank_tx_en   = en;
        rank_tx_data = d;
        credit_in    = cr;
        rdy = (m_count != DEPTH);
        acc = en && rdy;
        byp = BYP && acc && (m_count == 0) && (m_credit > 0);
        sf  = (m_count > 0) && (m_credit > 0);
        snd = sf || byp;
        ovf = cr && (m_credit == CREDIT) && !snd;
        check("router_rdy", {31'd0, router_rdy}, {31'd0, rdy});
        if (en && !rdy) m_err = 1'b1;
        if (ovf) m_err = 1'b1;
        if (acc) exp_q.push_back(d);
        if (cr && !ovf) m_credit++;
        if (snd) m_credit--;
        m_count = m_count + int'(acc && !byp) - int'(sf);
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_data_valid}, {31'd0, snd});
        if (out_data_valid) begin
            if (exp_q.size() == 0) begin
                check("stray_flit", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {24'd0, out_data}, {24'd0, e});
                last_data = e;
            end
        end else begin
            check("out_hold", {24'd0, out_data}, {24'd0, last_data});
        end
        check("credit_cnt", {28'd0, credit_cnt}, 32'(m_credit));
        check("inject_err", {31'd0, inject_err}, {31'd0, m_err});
        rank_tx_en = 1'b0;
        credit_in  = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_valid",  {31'd0, out_data_valid}, 32'd0);
        check("rst_data",   {24'd0, out_data}, 32'd0);
        check("rst_credit", {28'd0, credit_cnt}, 32'(CREDIT));
        check("rst_rdy",    {31'd0, router_rdy}, 32'd1);
        check("rst_err",    {31'd0, inject_err}, 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        rank_tx_en   = 1'b0;
        rank_tx_data = '0;
        credit_in    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b1;

        // Single packet, then return its credit.
        step(1'b1, 8'hA5, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Burst 1..8 with no credits returned: 1..4 emitted, 5..8 fill the FIFO.
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        check("burst_full_rdy", {31'd0, router_rdy}, 32'd0);
        check("burst_credit0", {28'd0, credit_cnt}, 32'd0);

        // One credit per cycle drains 5..8.
        repeat (4) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);
        check("drain_rdy", {31'd0, router_rdy}, 32'd1);

        // Fill with no credit, then write while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(8'h30 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        check("drop_err_sticky", {31'd0, inject_err}, 32'd1);
        repeat (4) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);

        // Three buffered with one credit, then asynchronous reset.
        for (int i = 0; i < 3; i++) step(1'b1, W'(8'h50 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        check("in_rst_valid", {31'd0, out_data_valid}, 32'd0);
        rst = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);

        // Credit return at full credit with no send.
        step(1'b0, '0, 1'b1);
        check("ovf_credit", {28'd0, credit_cnt}, 32'(CREDIT));
        check("ovf_err", {31'd0, inject_err}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                 1'(($urandom_range(0, 2) == 0) && (m_credit < CREDIT)));
        end
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'(m_credit < CREDIT));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
